// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: timed LED pattern sequencer (blink, chase, ping-pong).
// Start/stop handshake, programmable step period and step count, busy/done status.
// Optional build macro LED_PAUSE_EN adds a pause_in1 input that freezes stepping in RUN.
//
// state | meaning
// IDLE  | waiting for start, LEDs dark
// RUN   | pattern is being stepped, busy high
// DONE  | one-cycle completion pulse, LEDs dark
module led_seq_ctrl #(
    parameter int N_LEDS = 4,
    parameter int DIV_W  = 16
) (
    input  logic              clk_in1,
    input  logic              rst_in1,
    input  logic              start_in1,
    input  logic              stop_in1,
    input  logic [1:0]        mode_in1,
    input  logic [DIV_W-1:0]  period_in1,
    input  logic [7:0]        count_in1,
`ifdef LED_PAUSE_EN
    input  logic              pause_in1,
`endif
    output logic [N_LEDS-1:0] led_out1,
    output logic              busy_out1,
    output logic              done_out1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0]  PER_ONE = DIV_W'(1);
    localparam logic [N_LEDS-1:0] LED_LSB = N_LEDS'(1);

    state_t             state, state_n;
    logic [1:0]         mode_q, mode_n;
    logic [DIV_W-1:0]   period_q, period_n;
    logic [DIV_W-1:0]   presc_q, presc_n;
    logic [7:0]         count_q, count_n;
    logic [7:0]         step_q, step_n;
    logic               dir_q, dir_n;
    logic [N_LEDS-1:0]  leds_q, leds_n;
    logic [N_LEDS-1:0]  pat_next;
    logic               dir_step;
    logic               pause;

`ifdef LED_PAUSE_EN
    assign pause = pause_in1;
`else
    assign pause = 1'b0;
`endif

    // Register all sequencer state; reset returns to a dark, idle block.
    always_ff @(posedge clk_in1 or posedge rst_in1) begin
        if (rst_in1) begin
            state    <= IDLE;
            mode_q   <= 2'b00;
            period_q <= PER_ONE;
            presc_q  <= '0;
            count_q  <= '0;
            step_q   <= '0;
            dir_q    <= 1'b1;
            leds_q   <= '0;
        end else begin
            state    <= state_n;
            mode_q   <= mode_n;
            period_q <= period_n;
            presc_q  <= presc_n;
            count_q  <= count_n;
            step_q   <= step_n;
            dir_q    <= dir_n;
            leds_q   <= leds_n;
        end
    end

    // Pattern that the current one advances to on a step (dir_q = 1 means toward MSB).
    always_comb begin
        pat_next = leds_q;
        dir_step = dir_q;
        case (mode_q)
            2'b01: pat_next = (leds_q << 1) | (leds_q >> (N_LEDS - 1));
            2'b10: begin
                // A single LED has nowhere to bounce; it simply stays lit.
                if (N_LEDS > 1) begin
                    if (dir_q) begin
                        if (leds_q[N_LEDS-1]) begin
                            pat_next = leds_q >> 1;
                            dir_step = 1'b0;
                        end else begin
                            pat_next = leds_q << 1;
                        end
                    end else begin
                        if (leds_q[0]) begin
                            pat_next = leds_q << 1;
                            dir_step = 1'b1;
                        end else begin
                            pat_next = leds_q >> 1;
                        end
                    end
                end
            end
            default: pat_next = ~leds_q;
        endcase
    end

    // Next-state logic: start latching, prescaled stepping, completion and abort.
    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        period_n = period_q;
        presc_n  = presc_q;
        count_n  = count_q;
        step_n   = step_q;
        dir_n    = dir_q;
        leds_n   = leds_q;
        case (state)
            IDLE: begin
                if (start_in1 && !stop_in1) begin
                    mode_n   = mode_in1;
                    period_n = (period_in1 == '0) ? PER_ONE : period_in1;
                    count_n  = count_in1;
                    presc_n  = '0;
                    step_n   = '0;
                    dir_n    = 1'b1;
                    leds_n   = (mode_in1 == 2'b01 || mode_in1 == 2'b10) ? LED_LSB : '1;
                    state_n  = RUN;
                end
            end
            RUN: begin
                if (stop_in1) begin
                    state_n = IDLE;
                    leds_n  = '0;
                end else if (!pause) begin
                    if (presc_q == period_q - PER_ONE) begin
                        presc_n = '0;
                        step_n  = step_q + 8'd1;
                        if (count_q != 8'd0 && (step_q + 8'd1) == count_q) begin
                            state_n = DONE;
                            leds_n  = '0;
                        end else begin
                            leds_n = pat_next;
                            dir_n  = dir_step;
                        end
                    end else begin
                        presc_n = presc_q + PER_ONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                leds_n  = '0;
            end
            default: begin
                state_n = IDLE;
                leds_n  = '0;
            end
        endcase
    end

    assign led_out1  = leds_q;
    assign busy_out1 = (state == RUN);
    assign done_out1 = (state == DONE);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Testbench for led_seq_ctrl: directed plan plus randomized runs against a
// time-based reference model (pattern index = elapsed cycles / period).
// Pause coverage is compiled in when LED_PAUSE_EN is defined.
module tb_led_seq_ctrl;
    localparam int NL = 4;
    localparam int DW = 16;

    logic          clk_in1;
    logic          rst_in1;
    logic          start_in1;
    logic          stop_in1;
    logic [1:0]    mode_in1;
    logic [DW-1:0] period_in1;
    logic [7:0]    count_in1;
    logic          pause_sig;
    logic [NL-1:0] led_out1;
    logic          busy_out1;
    logic          done_out1;

    int checks = 0;
    int errors = 0;

    led_seq_ctrl #(.N_LEDS(NL), .DIV_W(DW)) dut (
        .clk_in1   (clk_in1),
        .rst_in1   (rst_in1),
        .start_in1 (start_in1),
        .stop_in1  (stop_in1),
        .mode_in1  (mode_in1),
        .period_in1(period_in1),
        .count_in1 (count_in1),
`ifdef LED_PAUSE_EN
        .pause_in1 (pause_sig),
`endif
        .led_out1  (led_out1),
        .busy_out1 (busy_out1),
        .done_out1 (done_out1)
    );

    initial begin
        clk_in1 = 1'b0;
        forever #5 clk_in1 = ~clk_in1;
    end

    // Expected LED pattern after k steps, from the pattern definitions.
    function automatic logic [NL-1:0] pat(input int m, input int k);
        logic [NL-1:0] v;
        int pos;
        int q;
        v = '0;
        if (m == 1) begin
            pos = k % NL;
            v[pos] = 1'b1;
        end else if (m == 2) begin
            if (NL == 1) pos = 0;
            else begin
                q   = k % (2 * NL - 2);
                pos = (q < NL) ? q : (2 * NL - 2 - q);
            end
            v[pos] = 1'b1;
        end else begin
            v = ((k % 2) == 0) ? '1 : '0;
        end
        return v;
    endfunction

    task automatic check_out(input string tag, input int t, input logic [NL-1:0] e_led,
                             input logic e_busy, input logic e_done);
        checks++;
        assert (led_out1 === e_led) else begin
            errors++;
            $error("FAIL %s led t=%0d observed=%b expected=%b", tag, t, led_out1, e_led);
        end
        checks++;
        assert (busy_out1 === e_busy) else begin
            errors++;
            $error("FAIL %s busy t=%0d observed=%b expected=%b", tag, t, busy_out1, e_busy);
        end
        checks++;
        assert (done_out1 === e_done) else begin
            errors++;
            $error("FAIL %s done t=%0d observed=%b expected=%b", tag, t, done_out1, e_done);
        end
    endtask

    // Start a run and check every cycle; t counts cycles since the start edge,
    // te counts only cycles where stepping was not paused.
    task automatic run_seq(input string tag, input int m, input int p, input int c,
                           input int ncyc, input int stop_at,
                           input int pause_at, input int pause_len);
        int ep;
        int tot;
        int te;
        logic pz;
        logic [NL-1:0] e_led;
        logic e_busy;
        logic e_done;
        int mm;
        mm  = (m == 3) ? 0 : m;
        ep  = (p == 0) ? 1 : p;
        tot = c * ep;
        mode_in1   = 2'(m);
        period_in1 = DW'(p);
        count_in1  = 8'(c);
        start_in1  = 1'b1;
        stop_in1   = 1'b0;
        @(negedge clk_in1);
        start_in1 = 1'b0;
        te = 0;
        for (int t = 0; t < ncyc; t++) begin
            if (stop_at >= 0 && t > stop_at) begin
                e_led = '0; e_busy = 1'b0; e_done = 1'b0;
            end else if (c != 0 && te == tot) begin
                e_led = '0; e_busy = 1'b0; e_done = 1'b1;
            end else if (c != 0 && te > tot) begin
                e_led = '0; e_busy = 1'b0; e_done = 1'b0;
            end else begin
                e_led = pat(mm, te / ep); e_busy = 1'b1; e_done = 1'b0;
            end
            check_out(tag, t, e_led, e_busy, e_done);
            // Configuration noise and ignored start requests while running/done.
            mode_in1   = 2'($urandom_range(0, 3));
            period_in1 = DW'($urandom_range(0, 7));
            count_in1  = 8'($urandom_range(0, 9));
            start_in1  = (e_busy || e_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            stop_in1   = (t == stop_at);
`ifdef LED_PAUSE_EN
            pz = e_busy && (t >= pause_at) && (t < pause_at + pause_len);
`else
            pz = 1'b0;
`endif
            pause_sig = pz;
            @(negedge clk_in1);
            if (!pz) te++;
        end
        start_in1 = 1'b0;
        stop_in1  = 1'b0;
        pause_sig = 1'b0;
    endtask

    initial begin
        int m, p, c, ncyc, stop_at, pa, pl, tot;
        rst_in1    = 1'b1;
        start_in1  = 1'b0;
        stop_in1   = 1'b0;
        mode_in1   = 2'b00;
        period_in1 = '0;
        count_in1  = '0;
        pause_sig  = 1'b0;
        #12;
        check_out("reset", 0, '0, 1'b0, 1'b0);
        @(negedge clk_in1);
        rst_in1 = 1'b0;
        @(negedge clk_in1);

        run_seq("blink", 0, 3, 4, 16, -1, 0, 0);
        run_seq("chase", 1, 1, 0, 12, 10, 0, 0);
        run_seq("pingpong", 2, 2, 0, 20, 18, 0, 0);
        run_seq("stop", 1, 5, 0, 12, 7, 0, 0);
        run_seq("reserved", 3, 1, 3, 6, -1, 0, 0);
        run_seq("stop_vs_done", 0, 2, 2, 6, 3, 0, 0);

        // Start together with stop must not start a run.
        mode_in1 = 2'b00; period_in1 = DW'(2); count_in1 = 8'd0;
        start_in1 = 1'b1; stop_in1 = 1'b1;
        @(negedge clk_in1);
        start_in1 = 1'b0; stop_in1 = 1'b0;
        check_out("start_stop", 0, '0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run.
        period_in1 = DW'(4); start_in1 = 1'b1;
        @(negedge clk_in1);
        start_in1 = 1'b0;
        check_out("pre_rst", 0, '1, 1'b1, 1'b0);
        @(posedge clk_in1);
        #2;
        rst_in1 = 1'b1;
        #1;
        check_out("async_rst", 0, '0, 1'b0, 1'b0);
        @(negedge clk_in1);
        rst_in1 = 1'b0;
        @(negedge clk_in1);
        check_out("post_rst", 0, '0, 1'b0, 1'b0);

        run_seq("zero_period", 0, 0, 0, 10, 8, 0, 0);
        run_seq("zero_period_cnt", 1, 0, 5, 8, -1, 0, 0);
        run_seq("pause", 0, 2, 0, 16, 14, 3, 6);

        for (int i = 0; i < 10; i++) begin
            m = $urandom_range(0, 3);
            p = $urandom_range(0, 4);
            c = $urandom_range(0, 6);
            pa = $urandom_range(1, 4);
            pl = $urandom_range(0, 4);
            if (c == 0) begin
                ncyc = 24;
                stop_at = $urandom_range(2, 21);
            end else begin
                tot = c * ((p == 0) ? 1 : p);
                ncyc = tot + pl + 3;
                stop_at = ($urandom_range(0, 3) == 0 && tot > 2) ? $urandom_range(0, tot - 2) : -1;
            end
            run_seq("random", m, p, c, ncyc, stop_at, pa, pl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Sequencer that drives a bank of LEDs with timed patterns (blink, chase, ping-pong) from the board clock.
- Sits between control logic and the LED pins, in place of wiring a clock straight to an LED.
- Provides a start/stop handshake, a programmable step period and a step count, with busy and done status.

Parameters:
- N_LEDS, 4, number of LED outputs (must be 1 or more).
- DIV_W, 16, width of the step-period field.

Ports:
- clk_in1, in, 1, system clock; all state changes on its rising edge.
- rst_in1, in, 1, asynchronous reset, active-high.
- start_in1, in, 1, start request; sampled only in IDLE.
- stop_in1, in, 1, abort request; sampled in RUN.
- mode_in1, in, 2, pattern: 00 blink, 01 chase, 10 ping-pong, 11 reserved (behaves as blink).
- period_in1, in, DIV_W, number of clock cycles each pattern step is held; 0 behaves as 1.
- count_in1, in, 8, number of steps before finishing; 0 means run until stopped.
- led_out1, out, N_LEDS, LED drive, 1 = lit.
- busy_out1, out, 1, high while in RUN.
- done_out1, out, 1, one-cycle pulse when a counted run completes.

Behaviour:
- Reset: async assert forces state IDLE with led_out1=0, busy_out1=0 and done_out1=0. Prescaler, step counter and direction clear. Reset mid-run aborts the run with no done pulse.
- State IDLE, on start_in1=1 and stop_in1=0:
  - Latch mode, period (0 becomes 1) and count.
  - Clear prescaler and step counter.
  - Load the initial pattern: blink = all ones; chase and ping-pong = LSB only, direction up.
  - Go to RUN. The pattern and busy_out1=1 are visible the cycle after the start edge.
- State IDLE, start_in1 and stop_in1 both high: no start.
- State RUN:
  - The prescaler increments every cycle.
  - When the prescaler equals period-1, a step occurs and the prescaler resets to 0. Each pattern is held exactly `period` cycles.
  - The step counter increments on each step, 8-bit.
  - When count≠0 and the step counter reaches count, go to DONE instead of updating the pattern.
- Step rules:
  - Blink: invert all bits.
  - Chase: rotate left; MSB wraps to LSB.
  - Ping-pong: shift in the current direction and reverse at either end, e.g. MSB is followed by MSB-1, never a repeat of MSB.
  - N_LEDS=1: chase and ping-pong hold the single LED lit.
- stop_in1 in RUN: next state is IDLE with led_out1=0 and no done pulse. Stop wins over a simultaneous step or completion.
- start_in1 in RUN is ignored. Latched configuration is not affected by input changes during RUN.
- State DONE, one cycle: led_out1=0, busy_out1=0, done_out1=1, then IDLE. start_in1 in DONE is ignored.
- With count=0, the step counter wraps at 255 without effect.

Optional Feature:
LED_PAUSE_EN
- Defined: adds input port pause_in1 (1 bit). While high in RUN, the prescaler and step logic freeze and led_out1 holds its value. Stop still takes effect during pause.
- Undefined: the port is absent and the block behaves as if pause were always 0.

Test Plan:
- Blink: N_LEDS=4, mode=00, period=3, count=4, pulse start.
  -> led_out1 shows 1111, 0000, 1111, 0000, each held 3 cycles.
  -> done_out1=1 for exactly 1 cycle with led_out1=0, then busy_out1=0.
- Chase: mode=01, period=1, count=0.
  -> led_out1 steps 0001, 0010, 0100, 1000, 0001 on consecutive cycles; busy_out1 stays 1 and done_out1 never pulses.
- Ping-pong: mode=10, period=2, count=0.
  -> led_out1 shows 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, each held 2 cycles.
- Stop mid-run: chase, period=5; assert stop_in1 on the 3rd prescaler cycle of the second pattern.
  -> next cycle led_out1=0000, busy_out1=0, done_out1 stays 0.
- Async reset and zero period: assert rst_in1 between clock edges during RUN.
  -> outputs go to 0 immediately, without waiting for an edge.
  -> after release, start with period=0 and mode=00: led_out1 toggles every cycle.
- Pause (LED_PAUSE_EN defined): blink, period=2; hold pause_in1 high for 6 cycles.
  -> led_out1 holds its value; stepping resumes with the remaining prescaler count.
